axi_phase_sequencer: RTL and testbench

Synthesizable run controller for the AXI4 width-converter bench. It sequences the per-phase traffic drivers: it pulses the four channel phase-start strobes, collects their done pulses, and advances `current_phase` through `TOTAL_TEST_COUNT / PHASE_TEST_COUNT` phases. It then runs the optional byte-verification phase and raises `test_execution_completed`. The logging monitor consumes its strobes unchanged; a watchdog flags a hung channel.

---
 rtl/axi_phase_sequencer.sv | 134 +++++++++++++
 tb/tb_axi_phase_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_phase_sequencer.sv
// Run controller for the AXI4 width-converter bench: steps the four channel
// drivers through every phase, then the optional byte-verification phase.
module axi_phase_sequencer #(
   parameter int TOTAL_TEST_COUNT         = 64,
   parameter int PHASE_TEST_COUNT         = 8,
   parameter int BYTE_VERIFICATION_ENABLE = 1,
   parameter int TIMEOUT_CYCLES           = 4096,
   parameter int PHASE_W                  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               write_addr_phase_done,
   input  logic               write_data_phase_done,
   input  logic               read_addr_phase_done,
   input  logic               read_data_phase_done,
   input  logic               byte_verification_channel_done,
   output logic               write_addr_phase_start,
   output logic               write_data_phase_start,
   output logic               read_addr_phase_start,
   output logic               read_data_phase_start,
   output logic [PHASE_W-1:0] current_phase,
   output logic               byte_verification_phase_start,
   output logic               byte_verification_phase_done,
   output logic               test_execution_completed,
   output logic               phase_timeout,
   output logic               busy,
   output logic [2:0]         dbg_state
);

   localparam int NUM_PHASES = (PHASE_TEST_COUNT > 0) ? TOTAL_TEST_COUNT / PHASE_TEST_COUNT : 1;
   localparam int REMAINDER  = (PHASE_TEST_COUNT > 0) ? TOTAL_TEST_COUNT % PHASE_TEST_COUNT : 0;
   localparam int CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);
   localparam bit                 WD_EN      = (TIMEOUT_CYCLES > 0);
   localparam bit                 BV_EN      = (BYTE_VERIFICATION_ENABLE != 0);

   if (PHASE_TEST_COUNT <= 0 || REMAINDER != 0) begin : g_bad_params
      $error("PHASE_TEST_COUNT must be >0 and divide TOTAL_TEST_COUNT");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_PH_START, S_PH_WAIT, S_BV_START,
      S_BV_WAIT, S_BV_DONE, S_COMPLETE, S_ERROR
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [3:0]         r_done_flags;
   logic [PHASE_W-1:0] r_phase;
   logic [CNT_W-1:0]   r_cnt;
   logic [3:0]         w_done_pulse;
   logic               w_all_done;
   logic               w_last_phase;
   logic               w_timeout;
   logic               w_can_start;

   // Same-cycle pulses count toward completion so the last done advances without a bubble.
   assign w_done_pulse = {write_addr_phase_done, write_data_phase_done,
                          read_addr_phase_done, read_data_phase_done};
   assign w_all_done   = &(r_done_flags | w_done_pulse);
   assign w_last_phase = (r_phase == LAST_PHASE);
   assign w_timeout    = WD_EN && (r_cnt == CNT_LAST);
   assign w_can_start  = (r_state == S_IDLE) || (r_state == S_COMPLETE) || (r_state == S_ERROR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_COMPLETE, S_ERROR: if (start) w_next = S_PH_START;
         S_PH_START: w_next = S_PH_WAIT;
         S_PH_WAIT: begin
            if (w_all_done) begin
               if (!w_last_phase) w_next = S_PH_START;
               else if (BV_EN)    w_next = S_BV_START;
               else               w_next = S_COMPLETE;
            end else if (w_timeout) begin
               w_next = S_ERROR;
            end
         end
         S_BV_START: w_next = S_BV_WAIT;
         S_BV_WAIT: begin
            if (byte_verification_channel_done) w_next = S_BV_DONE;
            else if (w_timeout)                 w_next = S_ERROR;
         end
         S_BV_DONE: w_next = S_COMPLETE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done_flags <= '0;
         r_phase      <= '0;
         r_cnt        <= '0;
      end else begin
         if (r_state == S_PH_START)     r_done_flags <= '0;
         else if (r_state == S_PH_WAIT) r_done_flags <= r_done_flags | w_done_pulse;

         if (w_can_start && start) r_phase <= '0;
         else if (r_state == S_PH_WAIT && w_all_done && !w_last_phase) r_phase <= r_phase + 1'b1;

         if (r_state == S_PH_START || r_state == S_BV_START) begin
            r_cnt <= '0;
         end else if ((r_state == S_PH_WAIT || r_state == S_BV_WAIT) && r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      write_addr_phase_start         = (r_state == S_PH_START);
      write_data_phase_start         = (r_state == S_PH_START);
      read_addr_phase_start          = (r_state == S_PH_START);
      read_data_phase_start          = (r_state == S_PH_START);
      byte_verification_phase_start  = (r_state == S_BV_START);
      byte_verification_phase_done   = (r_state == S_BV_DONE);
      test_execution_completed       = (r_state == S_COMPLETE);
      phase_timeout                  = (r_state == S_ERROR);
      busy                           = !w_can_start;
      current_phase                  = r_phase;
      dbg_state                      = r_state;
   end

endmodule

// File: tb/tb_axi_phase_sequencer.sv
// Directed bench: dut_a runs with byte verification and a 16-cycle watchdog,
// dut_b runs without byte verification and with the watchdog disabled.
module tb_axi_phase_sequencer;

   typedef struct {
      logic       sel;
      logic       st;
      logic [3:0] dn;
      logic       bv;
      logic       pst;
      logic [7:0] ph;
      logic       bvs;
      logic       bvd;
      logic       tec;
      logic       tmo;
      logic       busy;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       a_st, a_bv, b_st, b_bv;
   logic [3:0] a_dn, b_dn;
   logic       a_was, a_wds, a_ras, a_rds, a_bvs, a_bvd, a_tec, a_tmo, a_busy;
   logic       b_was, b_wds, b_ras, b_rds, b_bvs, b_bvd, b_tec, b_tmo, b_busy;
   logic [7:0] a_ph, b_ph;
   logic [2:0] a_dbg, b_dbg;

   int   n_checks = 0;
   int   n_errors = 0;
   vec_t vecs[$];

   axi_phase_sequencer #(
      .TOTAL_TEST_COUNT(16), .PHASE_TEST_COUNT(4), .BYTE_VERIFICATION_ENABLE(1),
      .TIMEOUT_CYCLES(16), .PHASE_W(8)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .start(a_st),
      .write_addr_phase_done(a_dn[3]), .write_data_phase_done(a_dn[2]),
      .read_addr_phase_done(a_dn[1]), .read_data_phase_done(a_dn[0]),
      .byte_verification_channel_done(a_bv),
      .write_addr_phase_start(a_was), .write_data_phase_start(a_wds),
      .read_addr_phase_start(a_ras), .read_data_phase_start(a_rds),
      .current_phase(a_ph), .byte_verification_phase_start(a_bvs),
      .byte_verification_phase_done(a_bvd), .test_execution_completed(a_tec),
      .phase_timeout(a_tmo), .busy(a_busy), .dbg_state(a_dbg)
   );

   axi_phase_sequencer #(
      .TOTAL_TEST_COUNT(16), .PHASE_TEST_COUNT(4), .BYTE_VERIFICATION_ENABLE(0),
      .TIMEOUT_CYCLES(0), .PHASE_W(8)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .start(b_st),
      .write_addr_phase_done(b_dn[3]), .write_data_phase_done(b_dn[2]),
      .read_addr_phase_done(b_dn[1]), .read_data_phase_done(b_dn[0]),
      .byte_verification_channel_done(b_bv),
      .write_addr_phase_start(b_was), .write_data_phase_start(b_wds),
      .read_addr_phase_start(b_ras), .read_data_phase_start(b_rds),
      .current_phase(b_ph), .byte_verification_phase_start(b_bvs),
      .byte_verification_phase_done(b_bvd), .test_execution_completed(b_tec),
      .phase_timeout(b_tmo), .busy(b_busy), .dbg_state(b_dbg)
   );

   function automatic logic [16:0] act(input logic sel);
      if (sel) return {b_was, b_wds, b_ras, b_rds, b_bvs, b_bvd, b_tec, b_tmo, b_busy, b_ph};
      return {a_was, a_wds, a_ras, a_rds, a_bvs, a_bvd, a_tec, a_tmo, a_busy, a_ph};
   endfunction

   function automatic logic [16:0] expv(input vec_t v);
      return {{4{v.pst}}, v.bvs, v.bvd, v.tec, v.tmo, v.busy, v.ph};
   endfunction

   task automatic check(input string name, input logic [16:0] got, input logic [16:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s got=%h want=%h (starts,bvs,bvd,tec,tmo,busy,phase)", name, got, want);
      end
   endtask

   function automatic void add(input logic sel, input logic st, input logic [3:0] dn,
                               input logic bv, input logic pst, input int ph,
                               input logic bvs, input logic bvd, input logic tec,
                               input logic tmo, input logic busy);
      vec_t v;
      v.sel = sel; v.st = st; v.dn = dn; v.bv = bv; v.pst = pst; v.ph = 8'(ph);
      v.bvs = bvs; v.bvd = bvd; v.tec = tec; v.tmo = tmo; v.busy = busy;
      vecs.push_back(v);
   endfunction

   task automatic drive_zero();
      a_st = 0; a_bv = 0; a_dn = '0;
      b_st = 0; b_bv = 0; b_dn = '0;
   endtask

   initial begin
      drive_zero();

      // dut_b: watchdog disabled, no byte verification
      add(1, 1, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 4'h0, 0, 1, 0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 20; k++) add(1, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 1);
      add(1, 0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 1);
      for (int p = 1; p < 4; p++) begin
         add(1, 0, 4'h0, 0, 1, p, 0, 0, 0, 0, 1);
         add(1, 0, 4'hF, (p == 3), 0, p, 0, 0, 0, 0, 1);
      end
      add(1, 0, 4'h0, 0, 0, 3, 0, 0, 1, 0, 0);
      add(1, 0, 4'h0, 0, 0, 3, 0, 0, 1, 0, 0);

      // dut_a: stray inputs in IDLE, then basic in-order run
      add(0, 0, 4'hF, 1, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int p = 0; p < 4; p++) begin
         add(0, 0, 4'h0, 0, 1, p, 0, 0, 0, 0, 1);
         add(0, 0, 4'h0, 0, 0, p, 0, 0, 0, 0, 1);
         add(0, 0, 4'h0, 0, 0, p, 0, 0, 0, 0, 1);
         add(0, 0, 4'hF, 0, 0, p, 0, 0, 0, 0, 1);
      end
      add(0, 0, 4'h0, 1, 0, 3, 1, 0, 0, 0, 1);
      add(0, 0, 4'h0, 0, 0, 3, 0, 0, 0, 0, 1);
      add(0, 0, 4'h0, 1, 0, 3, 0, 0, 0, 0, 1);
      add(0, 0, 4'h0, 0, 0, 3, 0, 1, 0, 0, 1);
      add(0, 0, 4'hF, 1, 0, 3, 0, 0, 1, 0, 0);
      add(0, 0, 4'h0, 0, 0, 3, 0, 0, 1, 0, 0);

      // dut_a: simultaneous dones, reverse order with duplicates, ignored start
      add(0, 1, 4'h0, 0, 0, 3, 0, 0, 1, 0, 0);
      add(0, 0, 4'h0, 0, 1, 0, 0, 0, 0, 0, 1);
      add(0, 0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 1);
      add(0, 0, 4'hF, 0, 1, 1, 0, 0, 0, 0, 1);
      add(0, 0, 4'h1, 0, 0, 1, 0, 0, 0, 0, 1);
      add(0, 1, 4'h3, 0, 0, 1, 0, 0, 0, 0, 1);
      add(0, 0, 4'h2, 0, 0, 1, 0, 0, 0, 0, 1);
      add(0, 0, 4'h4, 0, 0, 1, 0, 0, 0, 0, 1);
      add(0, 0, 4'h0, 0, 0, 1, 0, 0, 0, 0, 1);
      add(0, 0, 4'h8, 0, 0, 1, 0, 0, 0, 0, 1);
      add(0, 0, 4'h0, 0, 1, 2, 0, 0, 0, 0, 1);
      add(0, 0, 4'hF, 0, 0, 2, 0, 0, 0, 0, 1);
      add(0, 0, 4'h0, 0, 1, 3, 0, 0, 0, 0, 1);
      add(0, 0, 4'hF, 0, 0, 3, 0, 0, 0, 0, 1);
      add(0, 0, 4'h0, 0, 0, 3, 1, 0, 0, 0, 1);
      add(0, 0, 4'h0, 1, 0, 3, 0, 0, 0, 0, 1);
      add(0, 0, 4'h0, 0, 0, 3, 0, 1, 0, 0, 1);
      add(0, 0, 4'h0, 0, 0, 3, 0, 0, 1, 0, 0);

      // dut_a: watchdog fires in phase 2 with read_data done withheld
      add(0, 1, 4'h0, 0, 0, 3, 0, 0, 1, 0, 0);
      add(0, 0, 4'h0, 0, 1, 0, 0, 0, 0, 0, 1);
      add(0, 0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 1);
      add(0, 0, 4'h0, 0, 1, 1, 0, 0, 0, 0, 1);
      add(0, 0, 4'hF, 0, 0, 1, 0, 0, 0, 0, 1);
      add(0, 0, 4'h0, 0, 1, 2, 0, 0, 0, 0, 1);
      add(0, 0, 4'hE, 0, 0, 2, 0, 0, 0, 0, 1);
      for (int k = 1; k < 16; k++) add(0, 0, 4'h0, 0, 0, 2, 0, 0, 0, 0, 1);
      add(0, 0, 4'h1, 0, 0, 2, 0, 0, 0, 1, 0);
      add(0, 0, 4'h0, 0, 0, 2, 0, 0, 0, 1, 0);
      add(0, 1, 4'h0, 0, 0, 2, 0, 0, 0, 1, 0);

      // dut_a: last done lands in the timeout cycle, completion wins
      add(0, 0, 4'h0, 0, 1, 0, 0, 0, 0, 0, 1);
      add(0, 0, 4'h7, 0, 0, 0, 0, 0, 0, 0, 1);
      for (int k = 1; k < 15; k++) add(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 1);
      add(0, 0, 4'h8, 0, 0, 0, 0, 0, 0, 0, 1);
      for (int p = 1; p < 4; p++) begin
         add(0, 0, 4'h0, 0, 1, p, 0, 0, 0, 0, 1);
         add(0, 0, 4'hF, 0, 0, p, 0, 0, 0, 0, 1);
      end
      add(0, 0, 4'h0, 0, 0, 3, 1, 0, 0, 0, 1);
      add(0, 0, 4'h0, 0, 0, 3, 0, 0, 0, 0, 1);
      add(0, 0, 4'h0, 0, 0, 3, 0, 0, 0, 0, 1);

      repeat (3) @(negedge clk);
      check("reset_a", act(1'b0), 17'h0);
      check("reset_b", act(1'b1), 17'h0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         drive_zero();
         if (vecs[i].sel) begin
            b_st = vecs[i].st; b_dn = vecs[i].dn; b_bv = vecs[i].bv;
         end else begin
            a_st = vecs[i].st; a_dn = vecs[i].dn; a_bv = vecs[i].bv;
         end
         check($sformatf("vec%0d", i), act(vecs[i].sel), expv(vecs[i]));
      end

      // Asynchronous reset while dut_a sits in BV_WAIT
      @(negedge clk);
      drive_zero();
      check("bv_wait_hold", act(1'b0), {9'b0_0000_0001, 8'd3});
      #2 rst_n = 1'b0;
      #1 check("async_reset_a", act(1'b0), 17'h0);
      check("async_reset_b", act(1'b1), 17'h0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("in_reset%0d", k), act(1'b0), 17'h0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_idle", act(1'b0), 17'h0);
      a_st = 1'b1;
      @(negedge clk);
      a_st = 1'b0;
      check("post_reset_start", act(1'b0), {9'b1111_0000_1, 8'd0});

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
